uart_frame_packer: RTL

Periodic telemetry framer between the sensor/filter datapath and the byte-wide UART transmitter. Every PERIOD clocks it snapshots NCH channels of DW-bit samples and serialises them MSB-byte-first. The frame ends with an optional 8-bit additive checksum and a run of SYNC_LEN sync bytes. Each byte is handed over with a full send/done handshake, and frames that cannot start on time are counted.

---
 rtl/uart_frame_packer_if.sv | 37 +++
 rtl/uart_frame_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_packer_if
// Brief    : Channel-sample input and byte-wide UART handshake bundle for the
//            telemetry frame packer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_packer_if #(
    parameter int NCH = 3,
    parameter int DW  = 16
);
    logic [NCH*DW-1:0] ch_data;
    logic              tx_done;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              frame_busy;
    logic [7:0]        drop_cnt;

    modport master (
        input  ch_data,
        input  tx_done,
        output tx_data,
        output tx_send,
        output frame_busy,
        output drop_cnt
    );

    modport slave (
        output ch_data,
        output tx_done,
        input  tx_data,
        input  tx_send,
        input  frame_busy,
        input  drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_packer
// Brief    : Periodic telemetry framer: snapshots NCH channels every PERIOD
//            clocks and streams them MSB-byte-first, then checksum and sync.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_packer #(
    parameter int         NCH       = 3,
    parameter int         DW        = 16,
    parameter int         PERIOD    = 500000,
    parameter logic [7:0] SYNC_BYTE = 8'hFF,
    parameter int         SYNC_LEN  = 2,
    parameter int         CSUM_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_frame_packer_if.master bus
);

    localparam int c_BPC         = DW / 8;
    localparam int c_DATA_BYTES  = NCH * c_BPC;
    localparam int c_FRAME_BYTES = c_DATA_BYTES + CSUM_EN + SYNC_LEN;
    localparam int c_IW          = (c_FRAME_BYTES > 1) ? $clog2(c_FRAME_BYTES) : 1;
    localparam int c_CW          = $clog2(PERIOD);

    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_FRAME_BYTES - 1);
    localparam logic [c_IW-1:0] c_CSUM_IDX = c_IW'(c_DATA_BYTES);
    localparam logic [c_CW-1:0] c_TICK_CNT = c_CW'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CW-1:0]     r_count;
    logic                w_tick;
    logic [NCH*DW-1:0]   r_shadow;
    logic [c_IW-1:0]     r_idx;
    logic [c_IW-1:0]     w_idx_inc;
    logic [7:0]          r_csum;
    logic [7:0]          r_drop;
    logic [7:0]          w_data_bytes [c_DATA_BYTES];
    logic [7:0]          w_cur_byte;
    logic                w_cur_is_data;
    logic [7:0]          w_nxt_byte;
    logic                w_nxt_is_data;
    logic [7:0]          w_tx_data;

    assign w_tick    = (r_count == c_TICK_CNT);
    assign w_idx_inc = r_idx + c_IW'(1);

    // Frame-order view of the shadow: channel-major, MSB byte first.
    for (genvar g = 0; g < c_DATA_BYTES; g++) begin : g_bytes
        assign w_data_bytes[g] = r_shadow[(g / c_BPC) * DW + DW - 1 - 8 * (g % c_BPC) -: 8];
    end

    // Free-running period counter, never stalled by frame activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_state_nxt = ST_SEND;
            ST_SEND: if (bus.tx_done) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = (r_idx == c_LAST_IDX) ? ST_IDLE : ST_SEND;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cur_byte    = '0;
        w_cur_is_data = 1'b0;
        w_nxt_byte    = '0;
        w_nxt_is_data = 1'b0;
        for (int i = 0; i < c_DATA_BYTES; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_cur_byte    = w_data_bytes[i];
                w_cur_is_data = 1'b1;
            end
            if (w_idx_inc == c_IW'(i)) begin
                w_nxt_byte    = w_data_bytes[i];
                w_nxt_is_data = 1'b1;
            end
        end
    end

    always_comb begin
        w_tx_data = 8'h00;
        if (r_state == ST_SEND) begin
            if (w_cur_is_data) begin
                w_tx_data = w_cur_byte;
            end else if ((CSUM_EN != 0) && (r_idx == c_CSUM_IDX)) begin
                w_tx_data = r_csum;
            end else begin
                w_tx_data = SYNC_BYTE;
            end
        end
    end

    // Checksum picks up each data byte at the moment that byte enters SEND;
    // the first byte comes straight from ch_data since the shadow loads alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_csum   <= '0;
            r_drop   <= '0;
        end else begin
            if (w_tick && (r_state != ST_IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if ((r_state == ST_IDLE) && w_tick) begin
                r_shadow <= bus.ch_data;
                r_csum   <= bus.ch_data[DW-1 -: 8];
                r_idx    <= '0;
            end else if (r_state == ST_GAP) begin
                if (r_idx == c_LAST_IDX) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= w_idx_inc;
                    if (w_nxt_is_data) begin
                        r_csum <= r_csum + w_nxt_byte;
                    end
                end
            end
        end
    end

    assign bus.tx_send    = (r_state == ST_SEND);
    assign bus.tx_data    = w_tx_data;
    assign bus.frame_busy = (r_state != ST_IDLE);
    assign bus.drop_cnt   = r_drop;

endmodule
`default_nettype wire
